button_event_gen: RTL and testbench
===================================

Name: button_event_gen

Overview:
- Conditions the front-panel power and reset push-buttons and produces the 4-bit Interrupt event vector consumed by the interrupt controller.
- Synchronises, debounces and classifies each button independently into press and release events.
- Stretches each event so the downstream register logic cannot miss it.
- Also exports debounced button levels and an optional long-press forced-off request for the power sequencer.

Parameters:
- DEBOUNCE_CNT, 655, cycles the synchronised input must be stable before a transition is accepted (about 20 ms at 32.768 kHz); must be greater than PULSE_LEN.
- PULSE_LEN, 4, width in cycles of each event pulse on Interrupt; 1 to 15.
- LONG_PRESS_CNT, 131072, cycles of continuous debounced power-button press before ForceOffN asserts (about 4 s); used only with BTN_LONG_PRESS_EN.

Ports:
- CLK32768 in 1: 32.768 kHz system clock; all logic on its rising edge.
- ResetN in 1: synchronous, active-low reset.
- PwrBtnN in 1: raw power button, active low, asynchronous to CLK32768.
- RstBtnN in 1: raw reset button, active low, asynchronous.
- Interrupt out 4: [0] reset press, [1] reset release, [2] power press, [3] power release. Active-high, stretched pulses.
- PwrBtnState out 1: debounced power button, 1 = pressed.
- RstBtnState out 1: debounced reset button, 1 = pressed.
- ForceOffN out 1: active-low forced power-off request.

Behaviour:
- Clock and reset
  - One clock; reset is synchronous and active-low (ResetN sampled on CLK32768 rising edge).
  - Reset values: Interrupt = 4'h0, PwrBtnState = 0, RstBtnState = 0, ForceOffN = 1.
  - Reset also clears all counters and synchronisers, and puts both FSMs in ARM.
  - Reset asserted mid-debounce or mid-pulse aborts it immediately; no event is emitted.
- Synchronisation: each raw input passes a 2-flop synchroniser (reset value 1 = released) and is inverted to an active-high "pressed" signal P.
- Per-button FSM, identical for both buttons, one counter each, counter width $clog2(DEBOUNCE_CNT+1):
  - ARM: waits for P = 0 held for DEBOUNCE_CNT consecutive cycles, then goes to IDLE. No events in ARM, so a button stuck at power-up produces nothing.
  - IDLE: State = 0. P = 1 clears the counter and goes to PRESS_DB.
  - PRESS_DB: counts while P = 1. P = 0 returns to IDLE with no event. When the count reaches DEBOUNCE_CNT-1, go to PRESSED, set State = 1, fire the press event.
  - PRESSED: P = 0 clears the counter and goes to REL_DB.
  - REL_DB: counts while P = 0. P = 1 returns to PRESSED with no event. When the count reaches DEBOUNCE_CNT-1, go to IDLE, set State = 0, fire the release event.
- Latency: from the synchronised edge to State change and event is exactly DEBOUNCE_CNT cycles, plus 2 synchroniser cycles from the raw pin.
- Event stretch
  - A fired event sets its Interrupt bit on the next cycle and holds it exactly PULSE_LEN cycles, using a per-bit down-counter.
  - Because DEBOUNCE_CNT > PULSE_LEN, the same bit can never retrigger during a stretch; a generate-time check flags violation.
- Simultaneous events
  - Both buttons are fully independent.
  - Power and reset events in the same cycle assert both bits together; neither is dropped or serialised.
- Glitches: any bounce shorter than DEBOUNCE_CNT cycles produces no event and no State change.

Optional Feature:
- Macro: BTN_LONG_PRESS_EN.
- Defined:
  - An 18-bit+ saturating counter (width $clog2(LONG_PRESS_CNT+1)) increments while the power FSM is in PRESSED or REL_DB, and clears in IDLE.
  - When it reaches LONG_PRESS_CNT, ForceOffN goes 0 and stays 0 until the power FSM returns to IDLE, then goes 1 on the following cycle.
  - Press and release events on Interrupt are still generated normally.
- Undefined: ForceOffN is tied to 1 and no long-press counter is synthesised.

Test Plan:
- Reset behaviour: ResetN=0 for 3 cycles with PwrBtnN=0 held, then ResetN=1 with the button still held for 2000 cycles -> Interrupt stays 4'h0 and PwrBtnState stays 0. Then release the button and press it again cleanly -> Interrupt[2] pulses.
- Clean press (DEBOUNCE_CNT=8, PULSE_LEN=4): RstBtnN falls and stays low -> RstBtnState=1 and Interrupt[0]=1 for exactly 4 cycles, starting 8+2 (+1 stretch-register) cycles after the edge.
- Clean release (same parameters): RstBtnN rises and stays high -> Interrupt[1] pulses 4 cycles and RstBtnState=0.
- Bounce rejection: PwrBtnN toggles low 5 cycles / high 3 cycles repeatedly for 100 cycles -> no Interrupt bit set and PwrBtnState=0.
- Simultaneous press: both buttons fall on the same cycle -> Interrupt=4'b0101 for 4 cycles.
- Long press (BTN_LONG_PRESS_EN, LONG_PRESS_CNT=50, DEBOUNCE_CNT=8):
  - Hold power 70 cycles -> ForceOffN goes 0 50 cycles after PwrBtnState rises.
  - Release -> ForceOffN returns to 1 one cycle after the FSM reaches IDLE, and Interrupt[3] pulses.
- Reset mid-pulse: ResetN=0 on the 2nd cycle of an Interrupt[2] pulse -> Interrupt=0 the next cycle and no residual pulse after reset.

Source files
------------

// File: rtl/button_event_gen.sv
// button_event_gen: conditions the front-panel power and reset push-buttons.
// Each raw pin is synchronised, debounced and classified into press/release
// events that are stretched onto Interrupt[3:0]:
//   [0] reset press, [1] reset release, [2] power press, [3] power release.
// Debounced levels are exported on PwrBtnState/RstBtnState.
// Optional feature macro: BTN_LONG_PRESS_EN enables the long-press ForceOffN
// request; when undefined ForceOffN is tied high.
module button_event_gen #(
   parameter int unsigned DEBOUNCE_CNT   = 655,
   parameter int unsigned PULSE_LEN      = 4,
   parameter int unsigned LONG_PRESS_CNT = 131072
) (
   input  logic       CLK32768,
   input  logic       ResetN,
   input  logic       PwrBtnN,
   input  logic       RstBtnN,
   output logic [3:0] Interrupt,
   output logic       PwrBtnState,
   output logic       RstBtnState,
   output logic       ForceOffN
);

   localparam int unsigned DW      = $clog2(DEBOUNCE_CNT + 1);
   localparam int unsigned SW      = $clog2(PULSE_LEN + 1);
   localparam int unsigned BTN_RST = 0;
   localparam int unsigned BTN_PWR = 1;

   // ARM needs DEBOUNCE_CNT released samples; the debounce states count the
   // sample that caused entry, so they finish one count earlier.
   localparam logic [DW-1:0] CNT_ARM_DONE = DW'(DEBOUNCE_CNT - 1);
   localparam logic [DW-1:0] CNT_DB_DONE  = DW'(DEBOUNCE_CNT - 2);
   localparam logic [SW-1:0] PULSE_INIT   = SW'(PULSE_LEN);

   // A stretch must end before the same event can fire again.
   if (DEBOUNCE_CNT <= PULSE_LEN) begin : g_bad_debounce
      $error("button_event_gen: DEBOUNCE_CNT must be greater than PULSE_LEN");
   end
   if (PULSE_LEN < 1 || PULSE_LEN > 15) begin : g_bad_pulse
      $error("button_event_gen: PULSE_LEN must be 1 to 15");
   end
   if (LONG_PRESS_CNT < 1) begin : g_bad_long
      $error("button_event_gen: LONG_PRESS_CNT must be at least 1");
   end

   typedef enum logic [2:0] {
      ST_ARM,
      ST_IDLE,
      ST_PRESS_DB,
      ST_PRESSED,
      ST_REL_DB
   } btn_st_e;

   // Index 0 = reset button, index 1 = power button throughout.
   logic [1:0]    sync1_q, sync1_d;
   logic [1:0]    sync2_q, sync2_d;
   logic [1:0]    pressed;
   btn_st_e       st_q   [2];
   btn_st_e       st_d   [2];
   logic [DW-1:0] cnt_q  [2];
   logic [DW-1:0] cnt_d  [2];
   logic [1:0]    state_q, state_d;
   logic [3:0]    ev_q, ev_d;
   logic [SW-1:0] str_q  [4];
   logic [SW-1:0] str_d  [4];
   logic [3:0]    int_q, int_d;

   assign pressed = ~sync2_q;

   // Two-flop synchronisers for the asynchronous button pins.
   always_comb begin
      sync1_d = {PwrBtnN, RstBtnN};
      sync2_d = sync1_q;
   end

   // Per-button debounce FSM: next state, counter, level and event strobes.
   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      ev_d = '0;
      for (int b = 0; b < 2; b++) begin
         st_d[b]    = st_q[b];
         cnt_d[b]   = cnt_q[b];
         state_d[b] = state_q[b];
         case (st_q[b])
            ST_ARM: begin
               if (pressed[b]) begin
                  cnt_d[b] = '0;
               end else if (cnt_q[b] == CNT_ARM_DONE) begin
                  st_d[b]  = ST_IDLE;
                  cnt_d[b] = '0;
               end else begin
                  cnt_d[b] = cnt_q[b] + DW'(1);
               end
            end
            ST_IDLE: begin
               state_d[b] = 1'b0;
               if (pressed[b]) begin
                  cnt_d[b] = '0;
                  st_d[b]  = ST_PRESS_DB;
               end
            end
            ST_PRESS_DB: begin
               if (!pressed[b]) begin
                  st_d[b] = ST_IDLE;
               end else if (cnt_q[b] == CNT_DB_DONE) begin
                  st_d[b]     = ST_PRESSED;
                  state_d[b]  = 1'b1;
                  ev_d[2*b]   = 1'b1;
               end else begin
                  cnt_d[b] = cnt_q[b] + DW'(1);
               end
            end
            ST_PRESSED: begin
               if (!pressed[b]) begin
                  cnt_d[b] = '0;
                  st_d[b]  = ST_REL_DB;
               end
            end
            ST_REL_DB: begin
               if (pressed[b]) begin
                  st_d[b] = ST_PRESSED;
               end else if (cnt_q[b] == CNT_DB_DONE) begin
                  st_d[b]       = ST_IDLE;
                  state_d[b]    = 1'b0;
                  ev_d[2*b + 1] = 1'b1;
               end else begin
                  cnt_d[b] = cnt_q[b] + DW'(1);
               end
            end
            default: begin
               st_d[b]  = ST_ARM;
               cnt_d[b] = '0;
            end
         endcase
      end
   end

   // Event stretchers: a registered event loads a down-counter that holds
   // its Interrupt bit high for exactly PULSE_LEN cycles.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         if (ev_q[i]) begin
            str_d[i] = PULSE_INIT;
         end else if (str_q[i] != '0) begin
            str_d[i] = str_q[i] - SW'(1);
         end else begin
            str_d[i] = str_q[i];
         end
         int_d[i] = (str_d[i] != '0);
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge CLK32768) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!ResetN) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         state_q <= '0;
         ev_q    <= '0;
         int_q   <= '0;
         for (int b = 0; b < 2; b++) begin
            st_q[b]  <= ST_ARM;
            cnt_q[b] <= '0;
         end
         for (int i = 0; i < 4; i++) begin
            str_q[i] <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         ev_q    <= ev_d;
         int_q   <= int_d;
         for (int b = 0; b < 2; b++) begin
            st_q[b]  <= st_d[b];
            cnt_q[b] <= cnt_d[b];
         end
         for (int i = 0; i < 4; i++) begin
            str_q[i] <= str_d[i];
         end
      end
   end

   assign Interrupt   = int_q;
   assign RstBtnState = state_q[BTN_RST];
   assign PwrBtnState = state_q[BTN_PWR];

`ifdef BTN_LONG_PRESS_EN
   localparam int unsigned   LW     = $clog2(LONG_PRESS_CNT + 1);
   localparam logic [LW-1:0] LP_MAX = LW'(LONG_PRESS_CNT);

   logic [LW-1:0] lp_q, lp_d;
   logic          force_off_n_q, force_off_n_d;

   // Long-press timer: saturating count while the power button is held;
   // the request drops at the limit and clears once the FSM is back in IDLE.
   always_comb begin
      lp_d          = '0;
      force_off_n_d = force_off_n_q;
      if (st_q[BTN_PWR] == ST_PRESSED || st_q[BTN_PWR] == ST_REL_DB) begin
         lp_d = (lp_q == LP_MAX) ? lp_q : lp_q + LW'(1);
      end
      if (st_q[BTN_PWR] == ST_IDLE) begin
         force_off_n_d = 1'b1;
      end else if (lp_d == LP_MAX) begin
         force_off_n_d = 1'b0;
      end
   end

   // Long-press registers.
   always_ff @(posedge CLK32768) begin
      if (!ResetN) begin
         lp_q          <= '0;
         force_off_n_q <= 1'b1;
      end else begin
         lp_q          <= lp_d;
         force_off_n_q <= force_off_n_d;
      end
   end

   assign ForceOffN = force_off_n_q;
`else
   assign ForceOffN = 1'b1;
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// Testbench for button_event_gen with DEBOUNCE_CNT=8, PULSE_LEN=4,
// LONG_PRESS_CNT=50. Define BTN_LONG_PRESS_EN for both bench and RTL to
// exercise the long-press request.
module tb_button_event_gen;

   localparam int unsigned DEB  = 8;
   localparam int unsigned PLEN = 4;
   localparam int unsigned LONG = 50;
   // Raw pin change to first Interrupt cycle: 2 sync + DEB debounce + 1 stretch.
   localparam int LAT = DEB + 3;

   typedef struct {
      int idx;
      int start;
   } ev_t;

   logic       clk;
   logic       ResetN;
   logic       PwrBtnN;
   logic       RstBtnN;
   logic [3:0] Interrupt;
   logic       PwrBtnState;
   logic       RstBtnState;
   logic       ForceOffN;

   int  cyc;
   int  vectors;
   int  errors;
   bit  mon_en;
   ev_t sb[$];

   button_event_gen #(
      .DEBOUNCE_CNT   (DEB),
      .PULSE_LEN      (PLEN),
      .LONG_PRESS_CNT (LONG)
   ) dut (
      .CLK32768    (clk),
      .ResetN      (ResetN),
      .PwrBtnN     (PwrBtnN),
      .RstBtnN     (RstBtnN),
      .Interrupt   (Interrupt),
      .PwrBtnState (PwrBtnState),
      .RstBtnState (RstBtnState),
      .ForceOffN   (ForceOffN)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: expected Interrupt is rebuilt every cycle from the
   // queued events; expired events are popped once their window closes.
   always @(negedge clk) begin
      logic [3:0] exp_int;
      if (mon_en) begin
         exp_int = '0;
         foreach (sb[i]) begin
            if (cyc >= sb[i].start && cyc < sb[i].start + int'(PLEN))
               exp_int[sb[i].idx] = 1'b1;
         end
         vectors++;
         if (Interrupt !== exp_int) begin
            errors++;
            $display("FAIL interrupt cyc=%0d got=%b want=%b", cyc, Interrupt, exp_int);
         end
         while (sb.size() > 0 && cyc >= sb[0].start + int'(PLEN) - 1)
            sb.delete(0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // Drive both pins just after a rising edge; every clean level change
   // queues the event it must produce LAT cycles later.
   task automatic drive(input logic pwr_n, input logic rst_btn_n, output int c);
      ev_t e;
      @(posedge clk);
      #2;
      c = cyc;
      if (pwr_n !== PwrBtnN) begin
         e.idx = pwr_n ? 3 : 2;
         e.start = c + LAT;
         sb.push_back(e);
      end
      if (rst_btn_n !== RstBtnN) begin
         e.idx = rst_btn_n ? 1 : 0;
         e.start = c + LAT;
         sb.push_back(e);
      end
      PwrBtnN = pwr_n;
      RstBtnN = rst_btn_n;
   endtask

   task automatic goto_cyc(input int t);
      do @(negedge clk); while (cyc < t);
   endtask

   task automatic test_reset();
      int  c;
      bit  bad;
      ResetN  = 1'b0;
      PwrBtnN = 1'b0;
      RstBtnN = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (PwrBtnState !== 1'b0 || RstBtnState !== 1'b0 || ForceOffN !== 1'b1) begin
         errors++;
         $display("FAIL reset_values got pwr=%b rst=%b foff=%b want 0 0 1",
                  PwrBtnState, RstBtnState, ForceOffN);
      end
      @(posedge clk);
      #2 ResetN = 1'b1;
      bad = 0;
      repeat (2000) begin
         @(negedge clk);
         if (PwrBtnState !== 1'b0) bad = 1;
      end
      vectors++;
      if (bad) begin
         errors++;
         $display("FAIL stuck_at_powerup PwrBtnState went high, want 0");
      end
      @(posedge clk);
      #2 PwrBtnN = 1'b1;
      repeat (20) @(negedge clk);
      drive(1'b0, 1'b1, c);
      goto_cyc(c + DEB + 2);
      vectors++;
      if (PwrBtnState !== 1'b1) begin
         errors++;
         $display("FAIL rearm_press PwrBtnState got=%b want=1", PwrBtnState);
      end
      goto_cyc(c + 20);
      drive(1'b1, 1'b1, c);
      goto_cyc(c + 20);
   endtask

   task automatic test_clean_press();
      int c;
      drive(1'b1, 1'b0, c);
      goto_cyc(c + DEB + 1);
      vectors++;
      if (RstBtnState !== 1'b0) begin
         errors++;
         $display("FAIL press_early RstBtnState got=%b want=0", RstBtnState);
      end
      goto_cyc(c + DEB + 2);
      vectors++;
      if (RstBtnState !== 1'b1) begin
         errors++;
         $display("FAIL press_state RstBtnState got=%b want=1", RstBtnState);
      end
      goto_cyc(c + 20);
   endtask

   task automatic test_clean_release();
      int c;
      drive(1'b1, 1'b1, c);
      goto_cyc(c + DEB + 1);
      vectors++;
      if (RstBtnState !== 1'b1) begin
         errors++;
         $display("FAIL release_early RstBtnState got=%b want=1", RstBtnState);
      end
      goto_cyc(c + DEB + 2);
      vectors++;
      if (RstBtnState !== 1'b0) begin
         errors++;
         $display("FAIL release_state RstBtnState got=%b want=0", RstBtnState);
      end
      goto_cyc(c + 20);
   endtask

   task automatic test_bounce();
      bit bad;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #2 PwrBtnN = ((i % 8) < 5) ? 1'b0 : 1'b1;
         if (PwrBtnState !== 1'b0) bad = 1;
      end
      @(posedge clk);
      #2 PwrBtnN = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (PwrBtnState !== 1'b0) bad = 1;
      end
      vectors++;
      if (bad) begin
         errors++;
         $display("FAIL bounce PwrBtnState went high, want 0");
      end
   endtask

   task automatic test_simultaneous();
      int c;
      drive(1'b0, 1'b0, c);
      goto_cyc(c + LAT + 1);
      vectors++;
      if (Interrupt !== 4'b0101) begin
         errors++;
         $display("FAIL simul_press got=%b want=0101", Interrupt);
      end
      goto_cyc(c + 20);
      drive(1'b1, 1'b1, c);
      goto_cyc(c + LAT + 1);
      vectors++;
      if (Interrupt !== 4'b1010) begin
         errors++;
         $display("FAIL simul_release got=%b want=1010", Interrupt);
      end
      goto_cyc(c + 20);
   endtask

   task automatic test_long_press();
      int c;
      int r;
`ifdef BTN_LONG_PRESS_EN
      drive(1'b0, 1'b1, c);
      goto_cyc(c + DEB + 2 + LONG - 1);
      vectors++;
      if (ForceOffN !== 1'b1) begin
         errors++;
         $display("FAIL long_early ForceOffN got=%b want=1", ForceOffN);
      end
      goto_cyc(c + DEB + 2 + LONG);
      vectors++;
      if (ForceOffN !== 1'b0) begin
         errors++;
         $display("FAIL long_assert ForceOffN got=%b want=0", ForceOffN);
      end
      goto_cyc(c + 80);
      drive(1'b1, 1'b1, r);
      goto_cyc(r + DEB + 2);
      vectors++;
      if (ForceOffN !== 1'b0 || PwrBtnState !== 1'b0) begin
         errors++;
         $display("FAIL long_idle got foff=%b state=%b want 0 0", ForceOffN, PwrBtnState);
      end
      goto_cyc(r + DEB + 3);
      vectors++;
      if (ForceOffN !== 1'b1) begin
         errors++;
         $display("FAIL long_clear ForceOffN got=%b want=1", ForceOffN);
      end
      goto_cyc(r + 20);
`else
      bit bad;
      bad = 0;
      drive(1'b0, 1'b1, c);
      repeat (80) begin
         @(negedge clk);
         if (ForceOffN !== 1'b1) bad = 1;
      end
      drive(1'b1, 1'b1, r);
      repeat (20) begin
         @(negedge clk);
         if (ForceOffN !== 1'b1) bad = 1;
      end
      vectors++;
      if (bad) begin
         errors++;
         $display("FAIL force_off_tied ForceOffN went low, want 1");
      end
      vectors++;
      if (r - c < 70) begin
         errors++;
         $display("FAIL long_hold held=%0d want>=70", r - c);
      end
`endif
   endtask

   task automatic test_reset_mid_pulse();
      int c;
      int s;
      drive(1'b0, 1'b1, c);
      s = c + LAT;
      do begin
         @(posedge clk);
         #1;
      end while (cyc < s + 1);
      #1 ResetN = 1'b0;
      @(posedge clk);
      #1 sb.delete();
      @(negedge clk);
      vectors++;
      if (Interrupt !== 4'h0 || PwrBtnState !== 1'b0) begin
         errors++;
         $display("FAIL mid_pulse_reset got int=%b state=%b want 0000 0", Interrupt, PwrBtnState);
      end
      repeat (2) @(posedge clk);
      #2;
      ResetN  = 1'b1;
      PwrBtnN = 1'b1;
      repeat (40) @(negedge clk);
      vectors++;
      if (PwrBtnState !== 1'b0) begin
         errors++;
         $display("FAIL after_reset PwrBtnState got=%b want=0", PwrBtnState);
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      cyc     = 0;
      mon_en  = 1'b1;
      test_reset();
      test_clean_press();
      test_clean_release();
      test_bounce();
      test_simultaneous();
      test_long_press();
      test_reset_mid_pulse();
      mon_en = 1'b0;
      vectors++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
